// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the UART receive path; the transmit side reuses
// the frame length, state encoding and divider helpers.
package uart_rx_pkg;

    localparam int unsigned FRAME_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

    // Clock cycles per bit time (integer division, truncating).
    function automatic int unsigned uart_div(input int unsigned clk_hz,
                                             input int unsigned sclk_hz);
        return clk_hz / sclk_hz;
    endfunction

    // Cycles from the start edge to the middle of the start bit.
    function automatic int unsigned uart_half(input int unsigned clk_hz,
                                              input int unsigned sclk_hz);
        return uart_div(clk_hz, sclk_hz) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte output channel of the receiver: valid/ready holding register plus
// one-cycle error pulses.
interface uart_rx_if;

    logic [uart_rx_pkg::FRAME_BITS-1:0] data;
    logic                               valid;
    logic                               ready;
    logic                               frame_err;
    logic                               overrun;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        output ready
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for signals entering the clk domain from outside.
module sync_2ff #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling off a clock-derived bit timer, with a
// single-entry valid/ready holding register and framing/overrun pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned UART_CLK_HZ  = 510000000,
    parameter int unsigned UART_SCLK_HZ = 115200
) (
    input  logic clk,
    input  logic reset,
    input  logic uart_rxd,
    uart_rx_if.master rx
);

    localparam int unsigned DIV  = uart_div(UART_CLK_HZ, UART_SCLK_HZ);
    localparam int unsigned HALF = uart_half(UART_CLK_HZ, UART_SCLK_HZ);
    localparam int unsigned TW   = $clog2(DIV);

    localparam logic [TW-1:0] HALF_LOAD = TW'(HALF - 1);
    localparam logic [TW-1:0] DIV_LOAD  = TW'(DIV - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(FRAME_BITS - 1);

    logic                  rxd_s;
    rx_state_t             state_reg;
    logic [TW-1:0]         timer_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [2:0]            bit_idx_reg;
    logic                  frame_err_reg;
    logic [FRAME_BITS-1:0] data_reg;
    logic                  valid_reg;
    logic                  overrun_reg;

    logic timer_done;
    logic byte_done;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (reset),
        .d   (uart_rxd),
        .q   (rxd_s)
    );

    assign timer_done = (timer_reg == '0);

    // A good stop bit hands the shifted byte to the holding register this cycle.
    assign byte_done = (state_reg == ST_STOP) && timer_done && rxd_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            timer_reg     <= '0;
            shift_reg     <= '0;
            bit_idx_reg   <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        timer_reg <= HALF_LOAD;
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer_done) begin
                        if (!rxd_s) begin
                            timer_reg   <= DIV_LOAD;
                            bit_idx_reg <= '0;
                            state_reg   <= ST_DATA;
                        end else begin
                            // Line went back high before mid-start: a glitch.
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        timer_reg <= timer_reg - TW'(1);
                    end
                end
                ST_DATA: begin
                    if (timer_done) begin
                        shift_reg   <= {rxd_s, shift_reg[FRAME_BITS-1:1]};
                        timer_reg   <= DIV_LOAD;
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == LAST_BIT) begin
                            state_reg <= ST_STOP;
                        end
                    end else begin
                        timer_reg <= timer_reg - TW'(1);
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop keeps half a bit of slack for the next start edge.
                    if (timer_done) begin
                        if (rxd_s) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        timer_reg <= timer_reg - TW'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxd_s) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (byte_done) begin
                // A same-cycle accept frees the slot, so the new byte replaces it.
                if (!valid_reg || rx.ready) begin
                    data_reg  <= shift_reg;
                    valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (valid_reg && rx.ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign rx.data      = data_reg;
    assign rx.valid     = valid_reg;
    assign rx.frame_err = frame_err_reg;
    assign rx.overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=16: a frame driver pushes expected events into
// a queue, and a negedge monitor pops and compares each output event.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int DIV = 16;
    localparam int HALF = 8;
    // Pin edge to registered output: 2 sync flops + IDLE detect + HALF + 9 bit times.
    localparam int LAT = 3 + HALF + 9 * DIV;

    typedef enum logic [1:0] {EV_NONE, EV_DATA, EV_FERR, EV_OVR} ev_kind_t;

    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
        int         at;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rxd = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic valid_prev = 1'b0;
    logic hs_prev = 1'b0;

    uart_rx_if bus();

    uart_rx #(
        .UART_CLK_HZ  (16),
        .UART_SCLK_HZ (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .rx       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s = %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at #1 after an edge; returns at #1 after the edge ending the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input ev_kind_t kind, input logic [7:0] exp_data);
        exp_t e;
        e.kind = kind;
        e.data = exp_data;
        e.at   = cyc + LAT;
        if (kind != EV_NONE) exp_q.push_back(e);
        $display("send %02h stop=%0b at cycle %0d", b, stop, cyc);
        uart_rxd = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            wait_cycles(DIV);
        end
        uart_rxd = stop;
        wait_cycles(DIV);
    endtask

    task automatic mon_event(input ev_kind_t k);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL monitor: unexpected %s data %02h at cycle %0d", k.name(), bus.data, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.at != cyc || (k != EV_FERR && bus.data !== e.data)) begin
            errors++;
            $display("FAIL monitor: got %s data %02h cycle %0d, expected %s data %02h cycle %0d",
                     k.name(), bus.data, cyc, e.kind.name(), e.data, e.at);
        end else begin
            $display("rx   %s data %02h cycle %0d", k.name(), bus.data, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.frame_err) mon_event(EV_FERR);
            if (bus.overrun) mon_event(EV_OVR);
            if (bus.valid && (!valid_prev || hs_prev)) mon_event(EV_DATA);
        end
        valid_prev <= bus.valid;
        hs_prev    <= bus.valid && bus.ready;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ready = 1'b0;
        reset = 1'b1;
        wait_cycles(3);
        check("reset_valid", 32'(bus.valid), 32'h0);
        check("reset_data", 32'(bus.data), 32'h0);
        check("reset_frame_err", 32'(bus.frame_err), 32'h0);
        check("reset_overrun", 32'(bus.overrun), 32'h0);
        reset = 1'b0;
        wait_cycles(5);

        // Single byte with ready held high.
        bus.ready = 1'b1;
        send_frame(8'h55, 1'b1, EV_DATA, 8'h55);
        wait_cycles(10);

        // Overrun: two back-to-back frames with nobody consuming.
        bus.ready = 1'b0;
        send_frame(8'hA3, 1'b1, EV_DATA, 8'hA3);
        send_frame(8'h3C, 1'b1, EV_OVR, 8'hA3);
        wait_cycles(5);
        check("ovr_valid_held", 32'(bus.valid), 32'h1);
        check("ovr_data_held", 32'(bus.data), 32'hA3);
        bus.ready = 1'b1;
        wait_cycles(1);
        check("ovr_valid_drop", 32'(bus.valid), 32'h0);
        check("ovr_data_kept", 32'(bus.data), 32'hA3);
        wait_cycles(5);

        // Accept of 0x11 on exactly the completion cycle of 0x22.
        bus.ready = 1'b0;
        send_frame(8'h11, 1'b1, EV_DATA, 8'h11);
        fork
            send_frame(8'h22, 1'b1, EV_DATA, 8'h22);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1 bus.ready = 1'b1;
                @(posedge clk);
                #1 bus.ready = 1'b0;
                check("simul_data", 32'(bus.data), 32'h22);
                check("simul_valid", 32'(bus.valid), 32'h1);
                check("simul_overrun", 32'(bus.overrun), 32'h0);
            end
        join
        bus.ready = 1'b1;
        wait_cycles(5);

        // Framing error followed by a break held low.
        send_frame(8'hFF, 1'b0, EV_FERR, 8'h00);
        wait_cycles(40);
        check("break_state", 32'(dut.state_reg), 32'(ST_WAIT_HIGH));
        check("break_valid", 32'(bus.valid), 32'h0);
        uart_rxd = 1'b1;
        wait_cycles(20);
        check("break_recovered", 32'(dut.state_reg), 32'(ST_IDLE));
        send_frame(8'h0F, 1'b1, EV_DATA, 8'h0F);
        wait_cycles(10);

        // Start glitch shorter than half a bit.
        uart_rxd = 1'b0;
        wait_cycles(5);
        uart_rxd = 1'b1;
        wait_cycles(5);
        check("glitch_in_start", 32'(dut.state_reg), 32'(ST_START));
        wait_cycles(1);
        check("glitch_back_idle", 32'(dut.state_reg), 32'(ST_IDLE));
        wait_cycles(20);
        send_frame(8'hC3, 1'b1, EV_DATA, 8'hC3);
        wait_cycles(10);

        // Asynchronous reset during data bit 4 while a byte is being held.
        bus.ready = 1'b0;
        send_frame(8'h5A, 1'b1, EV_DATA, 8'h5A);
        wait_cycles(2);
        fork
            send_frame(8'hF0, 1'b1, EV_NONE, 8'h00);
            begin
                repeat (86) @(posedge clk);
                #2 reset = 1'b1;
                #1;
                check("areset_valid", 32'(bus.valid), 32'h0);
                check("areset_data", 32'(bus.data), 32'h0);
                check("areset_frame_err", 32'(bus.frame_err), 32'h0);
                check("areset_overrun", 32'(bus.overrun), 32'h0);
                check("areset_state", 32'(dut.state_reg), 32'(ST_IDLE));
                repeat (3) @(posedge clk);
                #1 reset = 1'b0;
            end
        join
        bus.ready = 1'b1;
        wait_cycles(10);
        send_frame(8'h81, 1'b1, EV_DATA, 8'h81);
        wait_cycles(20);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Asynchronous serial receiver, 8N1: LSB first, no parity, one stop bit.
- Samples the `uart_rxd` pin with a clock-derived bit timer and delivers each received byte through a single-entry valid/ready output register.
- Flags framing errors and overruns.
- Sits between the board's `uart_rxd` pin and the mini16 SoC I/O register that software polls.
- Complements the SoC's transmit path.

## Interface
- `UART_CLK_HZ`, default 510000000: `clk` frequency in Hz.
- `UART_SCLK_HZ`, default 115200: baud rate.
- `clk`  in  1: single clock for all logic.
- `reset`  in  1: asynchronous, active-high reset. Clears all state immediately, independent of `clk`.
- `uart_rxd`  in  1: serial line, asynchronous to `clk`. Idle level is 1.
- `data`  out  8: received byte. Stable while `valid`=1.
- `valid`  out  1: `data` holds an unconsumed byte.
- `ready`  in  1: consumer accepts `data` on any cycle where `valid`&`ready`=1.
- `frame_err`  out  1: one-cycle pulse; stop bit sampled as 0.
- `overrun`  out  1: one-cycle pulse; completed byte dropped because the holding register was full.

## Operation
- Constants:
  - DIV = UART_CLK_HZ / UART_SCLK_HZ, integer division; default value 4427.
  - HALF = DIV / 2.
  - Bit counter width = clog2(DIV), 13 bits at defaults.
- Input: `uart_rxd` passes through a 2-flop synchronizer (`rxd_s`), reset value 1. No other logic uses raw `uart_rxd`.
- State machine (reset state IDLE):
  - IDLE: when `rxd_s`=0, load timer with HALF-1 and go to START.
  - START: decrement timer. At timer=0:
    - `rxd_s`=0: load DIV-1, clear bit index, go to DATA.
    - `rxd_s`=1: treat as a glitch and return to IDLE.
  - DATA: at timer=0, shift `rxd_s` into shift-register bit 7 (right shift, LSB arrives first), reload DIV-1, increment bit index. After the 8th sample go to STOP.
  - STOP: at timer=0:
    - `rxd_s`=1: complete the byte and go to IDLE.
    - `rxd_s`=0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: remain until `rxd_s`=1, then go to IDLE. A break condition therefore produces exactly one `frame_err`.
- Holding register, on byte completion:
  - `valid`=0: load `data`, set `valid`=1.
  - `valid`=1 and `ready`=1 in the same cycle: load the new byte, `valid` stays 1, no overrun.
  - `valid`=1 and `ready`=0: keep old `data`, pulse `overrun`.
  - Otherwise `valid`&`ready` clears `valid`. `data` keeps its last value.
- Reset values: `valid`=0, `data`=0x00, `frame_err`=0, `overrun`=0, state IDLE, timer 0, shift register 0, bit index 0.
- Reset mid-byte abandons the frame. After reset release, reception restarts only at the next falling edge seen in IDLE. If the line is already low at release, that low is taken as a start bit.

## Timing
- Let t = the first cycle where `rxd_s`=0 in IDLE. Samples occur at:
  - start bit: t+HALF
  - data bit i (i=0..7): t+HALF+(i+1)·DIV
  - stop bit: t+HALF+9·DIV
- `valid` / `frame_err` / `overrun` are registered and assert at t+HALF+9·DIV+1.
- Pin-to-`rxd_s` latency: 2 cycles.
- `frame_err` and `overrun` are high for exactly one cycle per event. They are mutually exclusive for a given frame.
- Throughput: back-to-back frames with no idle gap are received. IDLE is re-entered at the stop sample, mid-stop-bit, so the next start edge is never missed.
- `ready` has no combinational path to any output.

## Structure
- Shared constants file `uart_defs.vh`:
  - state encodings (IDLE, START, DATA, STOP, WAIT_HIGH; 3 bits)
  - DIV/HALF derivation macro
  - frame length 8
- A future transmitter reuses these constants.
- One sub-module: `sync_2ff`. Parameterized width and reset value; async active-high reset.
- Timer, FSM, shift register and holding register live in `uart_rx`.

## Test plan
All scenarios use UART_CLK_HZ=16, UART_SCLK_HZ=1, giving DIV=16, HALF=8.
- **Single byte:** `ready`=1; drive frame 0x55 → `valid` pulses for 1 cycle with `data`=0x55 at t+153 (8+144+1); no error pulses.
- **Overrun:** `ready`=0; send 0xA3 then 0x3C back-to-back → `data`=0xA3, `valid` held, one `overrun` pulse at the second completion. Then raise `ready` → `valid` drops next cycle, `data` stays 0xA3.
- **Simultaneous accept and completion:** `valid`=1 with 0x11; assert `ready` on exactly the completion cycle of 0x22 → `data`=0x22, `valid`=1, `overrun`=0.
- **Framing error / break:** send 0xFF with stop bit 0, then hold the line low for 40 cycles → exactly one `frame_err` pulse, `valid` stays 0. FSM stays in WAIT_HIGH until the line returns to 1, then receives 0x0F correctly.
- **Start glitch:** line low for 5 cycles (<HALF) → no output, FSM back in IDLE at t+8. A following 0xC3 frame is received.
- **Reset mid-byte:** assert `reset` asynchronously during data bit 4 → all outputs 0 immediately, without waiting for a clock edge. After release, a 0x81 frame is received with `data`=0x81.
